// File: rtl/robot_wf_ctrl.sv
// Wall-following pipe-cleaning robot controller: selectable hand, timed trash removal, move budget.
// Optional stuck detection is built when ROBOT_STUCK_DETECT_EN is defined.
module robot_wf_ctrl #(
  parameter int REMOVE_CYCLES = 3,
  parameter int MOVE_LIMIT    = 0,
  parameter int STUCK_TURNS   = 4,
  parameter int TRASH_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hand,
  input  logic               head,
  input  logic               side,
  input  logic               under,
  input  logic               barrier,
  output logic               front,
  output logic               turn,
  output logic               turn_dir,
  output logic               remove,
  output logic               done,
  output logic               stuck,
  output logic [TRASH_W-1:0] trash_count
);

  localparam int RW = $clog2(REMOVE_CYCLES + 1);
  localparam int MW = (MOVE_LIMIT > 0) ? $clog2(MOVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {SEARCH, FOLLOW, REMOVE, STOP} state_t;

  state_t             state_q, state_d;
  logic               ret_q, ret_d;          // 1: REMOVE returns to FOLLOW
  logic               hand_q;
  logic               turned_q, turned_d;
  logic [RW-1:0]      rem_cnt_q, rem_cnt_d;
  logic [MW-1:0]      move_cnt_q, move_cnt_d;
  logic               front_q, front_d, turn_q, turn_d, turn_dir_q, turn_dir_d;
  logic               remove_q, remove_d, done_q, done_d, stuck_q, stuck_d;
  logic [TRASH_W-1:0] trash_q, trash_d;

  state_t             eval_st;
  logic               eval_en, want_front, want_turn, want_dir;

  logic unused_under;
  assign unused_under = under;

`ifdef ROBOT_STUCK_DETECT_EN
  localparam int TW = $clog2(STUCK_TURNS + 1);
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_base;
`else
  logic unused_stuck_param;
  assign unused_stuck_param = (STUCK_TURNS == 0);
`endif

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    turned_d   = turned_q;
    rem_cnt_d  = rem_cnt_q;
    move_cnt_d = move_cnt_q;
    front_d    = 1'b0;
    turn_d     = 1'b0;
    turn_dir_d = 1'b0;
    remove_d   = 1'b0;
    done_d     = done_q;
    stuck_d    = stuck_q;
    trash_d    = trash_q;
    eval_en    = 1'b0;
    eval_st    = state_q;
    want_front = 1'b0;
    want_turn  = 1'b0;
    want_dir   = 1'b0;
`ifdef ROBOT_STUCK_DETECT_EN
    tcnt_base  = tcnt_q;
`endif

    case (state_q)
      SEARCH, FOLLOW: eval_en = 1'b1;
      REMOVE: begin
        if (rem_cnt_q == RW'(REMOVE_CYCLES)) begin
          // Removal finished: account for it and decide the next action on this same edge.
          if (trash_q != '1) trash_d = trash_q + TRASH_W'(1);
`ifdef ROBOT_STUCK_DETECT_EN
          tcnt_base = '0;
`endif
          eval_en = 1'b1;
          eval_st = ret_q ? FOLLOW : SEARCH;
          state_d = eval_st;
        end else begin
          remove_d  = 1'b1;
          rem_cnt_d = rem_cnt_q + RW'(1);
        end
      end
      STOP: begin
        if (MOVE_LIMIT != 0 && move_cnt_q == MW'(MOVE_LIMIT)) done_d = 1'b1;
      end
      default: state_d = SEARCH;
    endcase

    if (eval_en) begin
      if (barrier && !head) begin
        state_d   = REMOVE;
        ret_d     = (eval_st == FOLLOW);
        remove_d  = 1'b1;
        rem_cnt_d = RW'(1);
      end else if (eval_st == SEARCH && !side) begin
        if (!head) begin
          want_front = 1'b1;
        end else begin
          want_turn = 1'b1;
          want_dir  = !hand_q;
          turned_d  = 1'b0;
          state_d   = FOLLOW;
        end
      end else begin
        state_d = FOLLOW;
        if (!side && !turned_q) begin
          want_turn = 1'b1;
          want_dir  = hand_q;
          turned_d  = 1'b1;
        end else if (!head) begin
          want_front = 1'b1;
          turned_d   = 1'b0;
        end else begin
          want_turn = 1'b1;
          want_dir  = !hand_q;
          turned_d  = 1'b0;
        end
      end
    end

`ifdef ROBOT_STUCK_DETECT_EN
    tcnt_d = tcnt_base;
`endif
    if (want_front) begin
      front_d    = 1'b1;
      move_cnt_d = move_cnt_q + MW'(1);
`ifdef ROBOT_STUCK_DETECT_EN
      tcnt_d     = '0;
`endif
      if (MOVE_LIMIT != 0 && move_cnt_d == MW'(MOVE_LIMIT)) state_d = STOP;
    end
    if (want_turn) begin
`ifdef ROBOT_STUCK_DETECT_EN
      if (tcnt_base == TW'(STUCK_TURNS)) begin
        state_d = STOP;
        stuck_d = 1'b1;
      end else begin
        turn_d     = 1'b1;
        turn_dir_d = want_dir;
        tcnt_d     = tcnt_base + TW'(1);
      end
`else
      turn_d     = 1'b1;
      turn_dir_d = want_dir;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SEARCH;
      ret_q      <= 1'b0;
      hand_q     <= hand;
      turned_q   <= 1'b0;
      rem_cnt_q  <= '0;
      move_cnt_q <= '0;
      front_q    <= 1'b0;
      turn_q     <= 1'b0;
      turn_dir_q <= 1'b0;
      remove_q   <= 1'b0;
      done_q     <= 1'b0;
      stuck_q    <= 1'b0;
      trash_q    <= '0;
`ifdef ROBOT_STUCK_DETECT_EN
      tcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      turned_q   <= turned_d;
      rem_cnt_q  <= rem_cnt_d;
      move_cnt_q <= move_cnt_d;
      front_q    <= front_d;
      turn_q     <= turn_d;
      turn_dir_q <= turn_dir_d;
      remove_q   <= remove_d;
      done_q     <= done_d;
      stuck_q    <= stuck_d;
      trash_q    <= trash_d;
`ifdef ROBOT_STUCK_DETECT_EN
      tcnt_q     <= tcnt_d;
`endif
    end
  end

  assign front       = front_q;
  assign turn        = turn_q;
  assign turn_dir    = turn_dir_q;
  assign remove      = remove_q;
  assign done        = done_q;
  assign stuck       = stuck_q;
  assign trash_count = trash_q;

endmodule

// File: tb/tb_robot_wf_ctrl.sv
// Directed-vector bench for robot_wf_ctrl (MOVE_LIMIT=5, REMOVE_CYCLES=3, STUCK_TURNS=4).
module tb_robot_wf_ctrl;

  logic clock = 1'b0;
  logic reset, hand, head, side, under, barrier;
  logic front, turn, turn_dir, remove, done, stuck;
  logic [7:0] trash_count;

  int n_vec = 0;
  int n_err = 0;

  robot_wf_ctrl #(
    .REMOVE_CYCLES(3), .MOVE_LIMIT(5), .STUCK_TURNS(4), .TRASH_W(8)
  ) dut (
    .clock(clock), .reset(reset), .hand(hand), .head(head), .side(side),
    .under(under), .barrier(barrier), .front(front), .turn(turn),
    .turn_dir(turn_dir), .remove(remove), .done(done), .stuck(stuck),
    .trash_count(trash_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, hnd, hd, sd, br;
    logic f, t, td, rm, dn;
    logic [7:0] tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, hnd, hd, sd, br, f, t, td, rm, dn, input logic [7:0] tc);
    vec_t v;
    v.rst = rst; v.hnd = hnd; v.hd = hd; v.sd = sd; v.br = br;
    v.f = f; v.t = t; v.td = td; v.rm = rm; v.dn = dn; v.tc = tc;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, hnd, hd, sd, br);
    reset = rst; hand = hnd; head = hd; side = sd; barrier = br;
    under = hd ^ sd;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic f, t, td, rm, dn, st, input logic [7:0] tc);
    n_vec++;
    if (front !== f || turn !== t || (t && turn_dir !== td) || remove !== rm ||
        done !== dn || stuck !== st || trash_count !== tc) begin
      n_err++;
      $display("FAIL %s: got f=%b t=%b td=%b rm=%b dn=%b st=%b tc=%0d, want f=%b t=%b td=%b rm=%b dn=%b st=%b tc=%0d",
               name, front, turn, turn_dir, remove, done, stuck, trash_count, f, t, td, rm, dn, st, tc);
    end
  endtask

  initial begin
    reset = 1'b1; hand = 1'b0; head = 1'b0; side = 1'b0; under = 1'b0; barrier = 1'b0;

    //  rst hnd hd sd br | f t td rm dn tc
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // reset state
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);  // corridor: 5 fronts
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);  // done the cycle after the 5th
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0);  // hand change ignored outside reset
    add(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);  // side drops: turn toward left
    add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // right hand
    add(0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0);  // removal, sensors toggled mid-way
    add(0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1,  0, 1, 1, 0, 0, 1);  // head beats barrier: turn away
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0);  // SEARCH blocked: turn away
    add(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0);  // FOLLOW: turn toward
    add(0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);  // SEARCH in open space: straight on
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].hnd, vecs[i].hd, vecs[i].sd, vecs[i].br);
      check($sformatf("vec%0d", i), vecs[i].f, vecs[i].t, vecs[i].td, vecs[i].rm, vecs[i].dn, 1'b0, vecs[i].tc);
    end

    // Reset during the second remove cycle
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); check("rm_first_done", 1, 0, 0, 0, 0, 0, 8'd1);
    step(0, 0, 0, 0, 1); check("rm2_cyc1", 0, 0, 0, 1, 0, 0, 8'd1);
    step(0, 0, 0, 0, 1); check("rm2_cyc2", 0, 0, 0, 1, 0, 0, 8'd1);
    step(1, 0, 0, 0, 1); check("rm_reset", 0, 0, 0, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0, 0); check("rm_after_reset", 1, 0, 0, 0, 0, 0, 8'd0);

    // Enclosed cell
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0); check($sformatf("encl_turn%0d", i), 0, 1, 1, 0, 0, 0, 8'd0);
    end
`ifdef ROBOT_STUCK_DETECT_EN
    step(0, 0, 1, 1, 0); check("encl_stuck", 0, 0, 0, 0, 0, 1, 8'd0);
    step(0, 0, 0, 0, 0); check("encl_stop_hold", 0, 0, 0, 0, 0, 1, 8'd0);
`else
    for (int i = 4; i < 24; i++) begin
      step(0, 0, 1, 1, 0); check($sformatf("encl_turn%0d", i), 0, 1, 1, 0, 0, 0, 8'd0);
    end
`endif

    // Back-to-back removals until trash_count saturates
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1);
    check("sat_first", 0, 0, 0, 1, 0, 0, 8'd1);
    for (int i = 5; i <= 800; i++) step(0, 0, 0, 0, 1);
    check("sat_full", 0, 0, 0, 1, 0, 0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
